// File: rtl/handshake_fifo_pkg.sv
// Shared constants and helpers for the req/ack elastic buffer.
// Also holds the transfer-counter type used by both sides of the channel.
package handshake_fifo_pkg;

    localparam int count_width = 32;

    typedef logic [count_width-1:0] count_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/handshake_fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module handshake_fifo_ram #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [depth];

    // NOTE: storage is deliberately not reset; the pointers and occupancy decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic buffer on a req/ack channel: consumer upstream, producer downstream.
// Every output is registered, so there is no combinational input-to-output path.
module handshake_fifo
    import handshake_fifo_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   occupancy,
    output logic                  overflow,
    output count_t                count_in,
    output count_t                count_out
);

    localparam logic [addr_width-1:0] ptr_one   = addr_width'(1);
    localparam logic [addr_width:0]   occ_one   = (addr_width + 1)'(1);
    localparam logic [addr_width:0]   occ_full  = (addr_width + 1)'(depth);
    localparam logic [addr_width+1:0] req_limit = (addr_width + 2)'(depth);
    localparam count_t                count_one = count_width'(1);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [data_width-1:0] head;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  inflight;
    logic [addr_width:0]   occ_next;
    logic [addr_width+1:0] req_sum;
    logic                  req_next;

    handshake_fifo_ram #(
        .data_width(data_width),
        .depth     (depth),
        .addr_width(addr_width)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_ptr),
        .rdata(head)
    );

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        full     = (occupancy == occ_full);
        push     = ack_l & ~full;
        // A pop needs a word already stored, so a word pushed into an empty FIFO waits one edge.
        pop      = req_r & ~ack_r & (occupancy != '0);
        inflight = req_l & ~ack_l;

        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + occ_one;
        end else if (pop && !push) begin
            occ_next = occupancy - occ_one;
        end

        // Reserve a slot for an ack that upstream may still send in response to the current req_l.
        req_sum  = {1'b0, occ_next} + {{(addr_width + 1){1'b0}}, inflight};
        req_next = (req_sum < req_limit);
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_l     <= 1'b0;
            ack_r     <= 1'b0;
            dout      <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            count_in  <= '0;
            count_out <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            req_l     <= req_next;
            ack_r     <= pop;
            occupancy <= occ_next;

            if (push) begin
                wr_ptr   <= wr_ptr + ptr_one;
                count_in <= count_in + count_one;
            end

            if (ack_l && full) begin
                overflow <= 1'b1;
            end

            if (pop) begin
                dout      <= head;
                rd_ptr    <= rd_ptr + ptr_one;
                count_out <= count_out + count_one;
            end
        end
    end

endmodule
